// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: ID-stage hazard controller bus
// master: pipeline side, drives IF/ID fields and branch_taken, observes controls and counters
// slave: hazard controller side, drives control_sel, write enables, flushes and event counters
interface hazard_control_unit_if #(parameter int CNT_W = 16);
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic branch_taken;
  logic control_sel;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic ex_mem_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output id_opcode, id_rs1, id_rs2, id_rd, branch_taken,
    input control_sel, pc_write, if_id_write, if_id_flush, ex_mem_flush, stall_count, flush_count
  );
  modport slave (
    input id_opcode, id_rs1, id_rs2, id_rd, branch_taken,
    output control_sel, pc_write, if_id_write, if_id_flush, ex_mem_flush, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall and taken-branch flush control for the 5-stage core
// clk: core clock; reset_n: synchronous active-low reset
// hz.id_*: IF/ID instruction fields; hz.branch_taken: PC target load from EX/MEM
// hz.control_sel/pc_write/if_id_write/if_id_flush/ex_mem_flush: pipeline controls
// hz.stall_count/flush_count: saturating debug event counters
module hazard_control_unit #(parameter int CNT_W = 16) (
  input logic clk,
  input logic reset_n,
  hazard_control_unit_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
  state_t state, state_nx;
  logic [4:0] ex_rd;
  logic ex_is_load;
  logic is_load, uses_rs1, uses_rs2, load_use, stall_ev, bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  always_comb begin
    is_load = hz.id_opcode == 7'b0000011;
    uses_rs1 = hz.id_opcode inside {7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011};
    uses_rs2 = hz.id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    // ex_rd of x0 never matches, so writes to x0 cannot stall
    load_use = ex_is_load && ex_rd != 5'd0 &&
               ((uses_rs1 && ex_rd == hz.id_rs1) || (uses_rs2 && ex_rd == hz.id_rs2));
    stall_ev = load_use && !hz.branch_taken;
    bubble = hz.branch_taken || load_use;
    hz.control_sel = bubble;
    hz.pc_write = !stall_ev;
    hz.if_id_write = !stall_ev;
    hz.if_id_flush = hz.branch_taken;
    hz.ex_mem_flush = hz.branch_taken;
    state_nx = hz.branch_taken ? FLUSH : (state == RUN && load_use) ? STALL : RUN;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      ex_rd <= 5'd0;
      ex_is_load <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      // a bubble or flush means nothing valid enters ID/EX
      ex_rd <= bubble ? 5'd0 : hz.id_rd;
      ex_is_load <= !bubble && is_load;
      if (stall_ev && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (hz.branch_taken && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;
endmodule
